// File: rtl/axis_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : axis_word_packer
// Brief    : Packs a narrow AXI-Stream into wide words, padding and flushing
//            partial words on tlast or after an idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module axis_word_packer #(
    parameter int unsigned         IN_WIDTH  = 32,
    parameter int unsigned         OUT_WIDTH = 128,
    parameter logic [IN_WIDTH-1:0] PAD_WORD  = '0,
    parameter int unsigned         TIMEOUT   = 1024
) (
    input  logic                                   aclk,
    input  logic                                   reset,
    input  logic [IN_WIDTH-1:0]                    in_tdata,
    input  logic                                   in_tvalid,
    output logic                                   in_tready,
    input  logic                                   in_tlast,
    output logic [OUT_WIDTH-1:0]                   out_tdata,
    output logic                                   out_tvalid,
    input  logic                                   out_tready,
    output logic                                   out_tlast,
    output logic [$clog2(OUT_WIDTH/IN_WIDTH):0]    out_lanes
);

    localparam int unsigned     c_ratio    = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned     c_iw       = $clog2(c_ratio);
    localparam int unsigned     c_lw       = c_iw + 1;
    localparam int unsigned     c_tw       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_iw-1:0] c_idx_last = c_iw'(c_ratio - 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [c_iw-1:0]      idx_q, idx_d;
    logic                 acc_full_q, acc_full_d;
    logic [c_lw-1:0]      acc_lanes_q, acc_lanes_d;
    logic                 acc_last_q, acc_last_d;
    logic [c_tw-1:0]      tmo_q, tmo_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [c_lw-1:0]      out_lanes_q, out_lanes_d;

    logic                 w_accept;
    logic                 w_out_free;
    logic                 w_close_word;
    logic                 w_expire;
    logic [c_lw-1:0]      w_lanes;
    logic [OUT_WIDTH-1:0] w_merged;

    assign w_accept     = in_tvalid & ~acc_full_q;
    assign w_out_free   = ~out_valid_q | out_tready;
    assign w_close_word = w_accept & ((idx_q == c_idx_last) | in_tlast);
    // An accepted word always beats the timeout in the same cycle.
    assign w_expire     = (TIMEOUT != 0) && (idx_q != '0) && !acc_full_q &&
                          !w_accept && (tmo_q == c_tmo_last);
    assign w_lanes      = w_close_word ? (c_lw'(idx_q) + c_lw'(1)) : c_lw'(idx_q);

    // Filled lanes keep their data, the incoming word lands at idx, the rest pad.
    always_comb begin
        w_merged = '0;
        for (int unsigned l = 0; l < c_ratio; l++) begin
            if (c_iw'(l) < idx_q) begin
                w_merged[l*IN_WIDTH +: IN_WIDTH] = acc_q[l*IN_WIDTH +: IN_WIDTH];
            end else if (w_accept && (c_iw'(l) == idx_q)) begin
                w_merged[l*IN_WIDTH +: IN_WIDTH] = in_tdata;
            end else begin
                w_merged[l*IN_WIDTH +: IN_WIDTH] = PAD_WORD;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        idx_d       = idx_q;
        acc_full_d  = acc_full_q;
        acc_lanes_d = acc_lanes_q;
        acc_last_d  = acc_last_q;
        tmo_d       = tmo_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_tready;
        out_last_d  = out_last_q;
        out_lanes_d = out_lanes_q;

        if (acc_full_q) begin
            if (w_out_free) begin
                out_data_d  = acc_q;
                out_lanes_d = acc_lanes_q;
                out_last_d  = acc_last_q;
                out_valid_d = 1'b1;
                acc_full_d  = 1'b0;
            end
        end else if (w_close_word || w_expire) begin
            idx_d = '0;
            tmo_d = '0;
            if (w_out_free) begin
                out_data_d  = w_merged;
                out_lanes_d = w_lanes;
                out_last_d  = w_close_word & in_tlast;
                out_valid_d = 1'b1;
            end else begin
                acc_d       = w_merged;
                acc_lanes_d = w_lanes;
                acc_last_d  = w_close_word & in_tlast;
                acc_full_d  = 1'b1;
            end
        end else if (w_accept) begin
            acc_d = w_merged;
            idx_d = idx_q + c_iw'(1);
            tmo_d = '0;
        end else if ((TIMEOUT != 0) && (idx_q != '0)) begin
            tmo_d = tmo_q + c_tw'(1);
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            idx_q       <= '0;
            acc_full_q  <= 1'b0;
            acc_lanes_q <= '0;
            acc_last_q  <= 1'b0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_lanes_q <= '0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            acc_full_q  <= acc_full_d;
            acc_lanes_q <= acc_lanes_d;
            acc_last_q  <= acc_last_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_lanes_q <= out_lanes_d;
        end
    end

    assign in_tready  = ~acc_full_q;
    assign out_tdata  = out_data_q;
    assign out_tvalid = out_valid_q;
    assign out_tlast  = out_last_q;
    assign out_lanes  = out_lanes_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_word_packer
// Brief    : Directed and random self-checking bench for axis_word_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_word_packer;

    localparam logic [31:0] c_pad = 32'hDEAD_BEEF;
    localparam int          c_tmo = 16;

    typedef struct {
        logic [127:0] data;
        logic [2:0]   lanes;
        logic         last;
    } beat_t;

    logic         aclk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  in_tdata = '0;
    logic         in_tvalid = 1'b0;
    logic         in_tready;
    logic         in_tlast = 1'b0;
    logic [127:0] out_tdata;
    logic         out_tvalid;
    logic         out_tready = 1'b1;
    logic         out_tlast;
    logic [2:0]   out_lanes;

    int    errors = 0;
    int    checks = 0;
    bit    rand_mode = 1'b0;
    beat_t exp_q[$];
    logic [32:0] word_q[$];

    axis_word_packer #(
        .IN_WIDTH (32),
        .OUT_WIDTH(128),
        .PAD_WORD (c_pad),
        .TIMEOUT  (c_tmo)
    ) dut (
        .aclk      (aclk),
        .reset     (reset),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .in_tlast  (in_tlast),
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready),
        .out_tlast (out_tlast),
        .out_lanes (out_lanes)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] a3, input logic [31:0] a2,
                                        input logic [31:0] a1, input logic [31:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic beat_t bt(input logic [127:0] d, input logic [2:0] n, input logic l);
        beat_t b;
        b.data  = d;
        b.lanes = n;
        b.last  = l;
        return b;
    endfunction

    // Monitor: handshakes are decided by values stable at the falling edge.
    bit           held = 1'b0;
    logic [131:0] held_val;
    bit           prev_valid = 1'b0;
    bit           prev_fire = 1'b0;
    int           since = 0;
    int           beat_gap = 0;

    always @(negedge aclk) begin
        if (reset) begin
            held = 1'b0;
            prev_valid = 1'b0;
            prev_fire = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 128'(out_tvalid), 128'(1));
                chk("hold_beat", 128'({out_tlast, out_lanes, out_tdata}), 128'(held_val));
            end
            if (out_tvalid && (!prev_valid || prev_fire)) beat_gap = since;
            if (in_tvalid && in_tready) begin
                since = 0;
                if (rand_mode) word_q.push_back({in_tlast, in_tdata});
            end else begin
                since++;
            end
            if (out_tvalid && out_tready) begin
                if (rand_mode) begin
                    logic  exp_last;
                    logic  early;
                    logic [32:0] w;
                    exp_last = 1'b0;
                    early = 1'b0;
                    chk("rand_lanes_range", 128'(out_lanes >= 3'd1 && out_lanes <= 3'd4), 128'(1));
                    for (int l = 0; l < 4; l++) begin
                        if (3'(l) < out_lanes) begin
                            if (word_q.size() == 0) begin
                                chk("rand_underflow", 128'(word_q.size()), 128'(1));
                            end else begin
                                w = word_q.pop_front();
                                chk("rand_data", 128'(out_tdata[l*32 +: 32]), 128'(w[31:0]));
                                if (3'(l) == out_lanes - 3'd1) exp_last = w[32];
                                else if (w[32]) early = 1'b1;
                            end
                        end else begin
                            chk("rand_pad", 128'(out_tdata[l*32 +: 32]), 128'(c_pad));
                        end
                    end
                    chk("rand_last", 128'(out_tlast), 128'(exp_last));
                    chk("rand_early_last", 128'(early), 128'(0));
                    if (out_lanes != 3'd4 && !out_tlast)
                        chk("rand_partial_is_timeout", 128'(beat_gap >= c_tmo), 128'(1));
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_tdata, 128'(0) - 128'(1) - out_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", out_tdata, e.data);
                    chk("beat_lanes", 128'(out_lanes), 128'(e.lanes));
                    chk("beat_last", 128'(out_tlast), 128'(e.last));
                end
            end
            held = out_tvalid && !out_tready;
            held_val = {out_tlast, out_lanes, out_tdata};
            prev_valid = out_tvalid;
            prev_fire = out_tvalid && out_tready;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int  k;
        bit  took;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        k = 0;
        took = 1'b0;
        while (!took) begin
            took = in_tready;
            tick();
            k++;
            if (!took && k > 200) begin
                chk("send_timeout", 128'(k), 128'(0));
                took = 1'b1;
            end
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int n;
        int cyc;
        int i;
        bit fired;

        // Reset state
        tick();
        tick();
        chk("rst_in_tready", 128'(in_tready), 128'(1));
        chk("rst_out_tvalid", 128'(out_tvalid), 128'(0));
        chk("rst_out_tdata", out_tdata, 128'(0));
        chk("rst_out_tlast_lanes", 128'({out_tlast, out_lanes}), 128'(0));
        reset = 1'b0;
        tick();

        // Two full beats, in_tready stays high
        out_tready = 1'b1;
        exp_q.push_back(bt(mk(32'd4, 32'd3, 32'd2, 32'd1), 3'd4, 1'b0));
        exp_q.push_back(bt(mk(32'd8, 32'd7, 32'd6, 32'd5), 3'd4, 1'b0));
        for (int k = 1; k <= 8; k++) begin
            chk("t1_in_tready", 128'(in_tready), 128'(1));
            send(32'(k), 1'b0);
        end
        drain("t1_drain");

        // tlast flush after three words, then tlast on lane 0
        exp_q.push_back(bt(mk(c_pad, 32'hC, 32'hB, 32'hA), 3'd3, 1'b1));
        exp_q.push_back(bt(mk(c_pad, c_pad, c_pad, 32'hD), 3'd1, 1'b1));
        send(32'hA, 1'b0);
        send(32'hB, 1'b0);
        send(32'hC, 1'b1);
        send(32'hD, 1'b1);
        drain("t2_drain");

        // Idle timeout: beat appears exactly c_tmo edges after the last accept
        exp_q.push_back(bt(mk(c_pad, c_pad, 32'h22, 32'h21), 3'd2, 1'b0));
        send(32'h21, 1'b0);
        send(32'h22, 1'b0);
        i = 0;
        while (i < 40) begin
            tick();
            i++;
            if (out_tvalid) break;
        end
        chk("t3_timeout_edges", 128'(i), 128'(c_tmo));
        drain("t3_drain");

        // Word arriving in the expiry cycle cancels the flush
        exp_q.push_back(bt(mk(32'h34, 32'h33, 32'h32, 32'h31), 3'd4, 1'b0));
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        for (int k = 0; k < c_tmo - 1; k++) tick();
        chk("t3b_no_early_flush", 128'(out_tvalid), 128'(0));
        send(32'h33, 1'b0);
        chk("t3b_no_flush_on_expiry", 128'(out_tvalid), 128'(0));
        send(32'h34, 1'b0);
        drain("t3b_drain");

        // Backpressure: first beat held, second fills the accumulator
        out_tready = 1'b0;
        exp_q.push_back(bt(mk(32'h104, 32'h103, 32'h102, 32'h101), 3'd4, 1'b0));
        exp_q.push_back(bt(mk(32'h108, 32'h107, 32'h106, 32'h105), 3'd4, 1'b0));
        exp_q.push_back(bt(mk(32'h10C, 32'h10B, 32'h10A, 32'h109), 3'd4, 1'b0));
        for (int k = 1; k <= 8; k++) send(32'h100 + 32'(k), 1'b0);
        chk("t4_in_tready_low", 128'(in_tready), 128'(0));
        tick();
        tick();
        tick();
        chk("t4_held_valid", 128'(out_tvalid), 128'(1));
        chk("t4_held_data", out_tdata, mk(32'h104, 32'h103, 32'h102, 32'h101));
        out_tready = 1'b1;
        for (int k = 9; k <= 12; k++) send(32'h100 + 32'(k), 1'b0);
        drain("t4_drain");

        // Reset with a held beat and a partial accumulator
        out_tready = 1'b0;
        for (int k = 1; k <= 7; k++) send(32'h200 + 32'(k), 1'b0);
        reset = 1'b1;
        #1;
        chk("t5_rst_out_tvalid", 128'(out_tvalid), 128'(0));
        chk("t5_rst_in_tready", 128'(in_tready), 128'(1));
        chk("t5_rst_out_lanes", 128'(out_lanes), 128'(0));
        tick();
        reset = 1'b0;
        out_tready = 1'b1;
        tick();
        exp_q.push_back(bt(mk(32'h304, 32'h303, 32'h302, 32'h301), 3'd4, 1'b0));
        for (int k = 1; k <= 4; k++) send(32'h300 + 32'(k), 1'b0);
        drain("t5_drain");

        // Random traffic reconstructed from out_lanes and out_tlast
        rand_mode = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 10000 && cyc < 80000) begin
            if (!in_tvalid && ($urandom_range(1, 0) == 1)) begin
                in_tvalid = 1'b1;
                in_tdata  = $urandom;
                in_tlast  = ($urandom_range(7, 0) == 0);
            end
            out_tready = ($urandom_range(1, 0) == 1);
            fired = in_tvalid && in_tready;
            tick();
            cyc++;
            if (fired) begin
                n++;
                in_tvalid = 1'b0;
                in_tlast  = 1'b0;
            end
        end
        chk("rand_words_sent", 128'(n), 128'(10000));
        out_tready = 1'b1;
        send(32'h5A5A_A5A5, 1'b1);
        i = 0;
        while ((word_q.size() != 0 || out_tvalid) && i < 100) begin
            tick();
            i++;
        end
        chk("rand_drain", 128'(word_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
